// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master RAM / memory-mapped I/O arbiter.
// Bus commands, FSM states, I/O addresses and the address decoder.
package mem_bus_pkg;

    localparam logic [1:0] MREAD  = 2'd1;
    localparam logic [1:0] MNONE  = 2'd2;
    localparam logic [1:0] MWRITE = 2'd3;

    localparam logic [8:0] LED_ADDR = 9'h100;
    localparam logic [8:0] SW_ADDR  = 9'h140;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        T_RAM,
        T_LED,
        T_SW,
        T_NONE
    } addr_target_t;

    function automatic logic cmd_valid(input logic [1:0] c);
        return (c == MREAD) || (c == MWRITE);
    endfunction

    // RAM owns the whole lower half; the upper half is sparse I/O.
    function automatic addr_target_t decode(input logic [8:0] a);
        if (!a[8]) begin
            return T_RAM;
        end
        if (a == LED_ADDR) begin
            return T_LED;
        end
        if (a == SW_ADDR) begin
            return T_SW;
        end
        return T_NONE;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick: ptr names the requester favoured on a tie.
// Purely combinational; the pointer register lives in the parent.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] win_o
);

    always_comb begin
        win_o = 2'b00;
        case (valid_i)
            2'b01:   win_o = 2'b01;
            2'b10:   win_o = 2'b10;
            2'b11:   win_o = ptr_i ? 2'b10 : 2'b01;
            default: win_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates CPU and loader access to the shared RAM, LED and switches
// through a fixed IDLE -> ACCESS -> RESP sequence per transaction.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9,
    parameter int RAM_AW = 8,
    parameter int IO_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        cmd0,
    input  logic [1:0]        cmd1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              bad_addr,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic [IO_W-1:0]   sw,
    output logic [IO_W-1:0]   ledr
);

    state_t              state_q, state_d;
    logic                rr_q, rr_d;
    logic                wid_q, wid_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [IO_W-1:0]     led_q, led_d;
    logic [IO_W-1:0]     sw_q, sw_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [1:0]          valid;
    logic [1:0]          win;
    addr_target_t        tgt;

    assign valid[0] = req[0] & cmd_valid(cmd0);
    assign valid[1] = req[1] & cmd_valid(cmd1);
    assign tgt      = decode(addr_q);
    assign ledr     = led_q;

    rr_arb2 u_arb (
        .valid_i (valid),
        .ptr_i   (rr_q),
        .win_o   (win)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            wid_q   <= 1'b0;
            cmd_q   <= MNONE;
            addr_q  <= '0;
            wdata_q <= '0;
            led_q   <= '0;
            sw_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            wid_q   <= wid_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            led_q   <= led_d;
            sw_q    <= sw_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        wid_d     = wid_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        led_d     = led_q;
        sw_d      = sw_q;
        rdata_d   = rdata_q;
        gnt       = 2'b00;
        ack       = 2'b00;
        bad_addr  = 1'b0;
        ram_addr  = '0;
        ram_write = 1'b0;
        ram_din   = '0;
        rdata     = rdata_q;

        unique case (state_q)
            IDLE: begin
                // Grant is combinational, so it must be masked while in reset.
                if (reset && (win != 2'b00)) begin
                    gnt     = win;
                    wid_d   = win[1];
                    cmd_d   = win[1] ? cmd1 : cmd0;
                    addr_d  = win[1] ? addr1 : addr0;
                    wdata_d = win[1] ? wdata1 : wdata0;
                    rr_d    = ~win[1];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (tgt == T_RAM) begin
                    ram_addr  = addr_q[RAM_AW-1:0];
                    ram_din   = wdata_q;
                    ram_write = (cmd_q == MWRITE);
                end
                if ((cmd_q == MWRITE) && (tgt == T_LED)) begin
                    led_d = wdata_q[IO_W-1:0];
                end
                sw_d    = sw;
                state_d = RESP;
            end
            RESP: begin
                ack = wid_q ? 2'b10 : 2'b01;
                if (cmd_q == MREAD) begin
                    unique case (tgt)
                        T_RAM:   rdata_d = ram_dout;
                        T_LED:   rdata_d = {{(DATA_W-IO_W){1'b0}}, led_q};
                        T_SW:    rdata_d = {{(DATA_W-IO_W){1'b0}}, sw_q};
                        default: begin
                            rdata_d  = '0;
                            bad_addr = 1'b1;
                        end
                    endcase
                    // RAM data only arrives this cycle, so bypass the register.
                    rdata = rdata_d;
                end else begin
                    bad_addr = (tgt == T_NONE);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 256x16 RAM and the memory-mapped I/O (LED register, slide switches) between two bus masters: requester 0 (CPU) and requester 1 (debug/program loader).
- Arbitrates with a round-robin policy and sequences every transaction through a fixed 3-cycle grant/access/response pipeline.
- Decodes addresses and steers read data back to the winning requester.
- Sits between the masters and the RAM/I/O in the top level, replacing the ad-hoc tri-state read_data decode.

Parameters:
- DATA_W, 16, data bus width
- ADDR_W, 9, bus address width
- RAM_AW, 8, RAM address width (RAM occupies addr[8]==0)
- LED_ADDR, 9'h100, LED register address
- SW_ADDR, 9'h140, switch input address
- IO_W, 8, LED/switch width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  2  per-requester request, level
- cmd0, cmd1  in  2 each  MREAD=1, MNONE=2, MWRITE=3
- addr0, addr1  in  ADDR_W each  request address
- wdata0, wdata1  in  DATA_W each  write data
- gnt  out  2  one-hot grant pulse; request accepted this cycle
- ack  out  2  one-hot completion pulse
- rdata  out  DATA_W  read data, valid when ack is high for a read
- bad_addr  out  1  pulse with ack when the access decoded to no target
- ram_addr  out  RAM_AW  RAM address
- ram_write  out  1  RAM write enable
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data (synchronous read, 1-cycle latency)
- sw  in  IO_W  slide switches
- ledr  out  IO_W  LED register

Behaviour:
- Reset (async, reset==0) forces:
  - state=IDLE, rr pointer=0 (requester 0 favoured), ledr=0
  - gnt, ack, bad_addr, ram_write all 0; rdata=0; ram_addr/ram_din=0
  - any in-flight transaction is dropped with no ack.
- A requester is "valid" when req[i]=1 and cmd_i is MREAD or MWRITE. MNONE or 0 is ignored.
- FSM states IDLE -> ACCESS -> RESP -> IDLE. Each transaction takes exactly 3 cycles. There is no back-to-back overlap.
- IDLE (cycle T):
  - If exactly one requester is valid, it wins. If both are valid, the rr pointer selects the winner.
  - gnt[w]=1 combinationally during T.
  - At the clock edge: latch w, cmd, addr, wdata; set rr pointer=~w; go to ACCESS.
  - If no requester is valid, stay in IDLE with gnt=0.
- ACCESS (T+1), driven from the latched values:
  - ram_addr=addr[7:0] and ram_din=wdata whenever addr[8]==0.
  - ram_write=1 only when cmd=MWRITE and addr[8]==0.
  - MWRITE to LED_ADDR: ledr<=wdata[7:0] at the end of T+1.
  - sw is sampled into a register at the end of T+1.
  - Go to RESP.
- RESP (T+2): ack[w]=1. For MREAD, rdata is selected by address:
  - RAM: ram_dout
  - LED_ADDR: {8'h00, ledr}
  - SW_ADDR: {8'h00, sampled sw}
  - anything else: 16'h0000 with bad_addr=1
- RESP, MWRITE cases:
  - rdata holds its previous value.
  - MWRITE to SW_ADDR is ignored (bad_addr=0).
  - MWRITE to any other non-RAM, non-LED address: bad_addr=1.
  - Go to IDLE.
- rdata is registered and holds its value between acks.
- Requests presented during ACCESS or RESP get no gnt and are held off until IDLE. A requester keeps req high until it sees gnt.
- Ordering: a write granted before a read to the same RAM address is visible to that read, because the write commits in ACCESS before the read's ACCESS.
- Fairness: under continuous contention, grants alternate 0,1,0,1...
- Reset asserted mid-ACCESS suppresses any further ram_write. The RAM contents themselves are not reset.

Decomposition:
- Shared package mem_bus_pkg:
  - MREAD/MNONE/MWRITE constants
  - state enum {IDLE, ACCESS, RESP}
  - LED_ADDR and SW_ADDR
  - addr_target enum {T_RAM, T_LED, T_SW, T_NONE}
- Sub-module rr_arb2 (2-way round-robin: valid[1:0], pointer -> one-hot winner). Pure combinational; the pointer register lives in the parent.
- Address decode is a function in the package.

Test Plan:
- Reset, then CPU MWRITE addr 9'h005 data 16'hABCD -> gnt[0] at T, ram_write=1 with ram_addr=8'h05 at T+1, ack[0] at T+2, bad_addr=0. Then CPU MREAD 9'h005 -> ack[0] with rdata=16'hABCD.
- Both requesters MREAD every cycle from reset, 6 transactions -> gnt order 0,1,0,1,0,1, each ack exactly 2 cycles after its gnt.
- MWRITE 9'h100 data 16'h1234 -> ledr=8'h34 after T+1. MREAD 9'h140 with sw=8'h5A -> rdata=16'h005A.
- MREAD 9'h1FF -> rdata=16'h0000 with bad_addr=1. MWRITE 9'h180 -> no ram_write, ledr unchanged, bad_addr=1.
- req[0]=1 with cmd0=MNONE while requester 1 issues MREAD -> only gnt[1], no gnt[0].
- reset driven low during ACCESS of a write to 9'h010 -> ram_write drops immediately, no ack, state returns to IDLE, ledr=0, next grant goes to requester 0.
